// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction-memory loader. Receives a length-
//               prefixed program image as a byte stream (valid/ready),
//               assembles big-endian 32-bit words, writes them sequentially
//               into instruction memory from byte address 0, and releases
//               the core (cpu_run) once the whole image has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int MAX_WORDS = 256,  // largest legal image, in words
    parameter int CNT_W     = 16    // length field / word counter width
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_req,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        cpu_run,
    output logic        error
);

    // Upper bound as an unsigned 32-bit value so the length check never
    // goes through a signed integer compare.
    localparam logic [31:0] c_MAX_WORDS = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [7:0]         r_len_hi;     // first (MSB) length byte
    logic [CNT_W-1:0]   r_len;        // image length N in words
    logic [CNT_W-1:0]   r_word_idx;   // index of the word being assembled
    logic [1:0]         r_byte_cnt;   // bytes of the current word received
    logic [31:0]        r_word;       // word shift register, MSB first

    logic               w_can_accept;
    logic               w_xfer;
    logic [15:0]        w_len_rx;
    logic               w_len_bad;
    logic [CNT_W-1:0]   w_idx_inc;
    logic               w_last_word;

    // The ready decision depends on state only, so there is no path from
    // byte_valid back to byte_ready.
    assign w_can_accept = (r_state == S_LEN_HI) ||
                          (r_state == S_LEN_LO) ||
                          (r_state == S_DATA);
    assign w_xfer       = byte_valid && w_can_accept;

    // Full length as seen during the LEN_LO transfer.
    assign w_len_rx     = {r_len_hi, byte_in};
    assign w_len_bad    = (w_len_rx == 16'd0) ||
                          ({16'd0, w_len_rx} > c_MAX_WORDS);

    assign w_idx_inc    = r_word_idx + CNT_W'(1);
    assign w_last_word  = (w_idx_inc == r_len);

    // Memory write port: address is the word index scaled to bytes, so it
    // is word-aligned by construction.
    assign imem_addr    = {{(30 - CNT_W){1'b0}}, r_word_idx, 2'b00};
    assign imem_wdata   = r_word;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs; load_req overrides everything,
    // including a byte offered in the same cycle.
    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        cpu_run    = 1'b0;
        error      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = r_state;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_xfer) begin
                    w_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_xfer) begin
                    w_next = w_len_bad ? S_ERROR : S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_xfer && (r_byte_cnt == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                w_next  = w_last_word ? S_DONE : S_DATA;
            end
            S_DONE: begin
                cpu_run = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (load_req) begin
            w_next = S_LEN_HI;
        end
    end

    // Datapath: length capture, word assembly and write-index tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len_hi   <= 8'd0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= 2'd0;
            r_word     <= 32'd0;
        end else if (load_req) begin
            // Restart: already written words stay in memory and are simply
            // overwritten by the new image.
            r_word_idx <= '0;
            r_byte_cnt <= 2'd0;
        end else begin
            case (r_state)
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= byte_in;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_len      <= CNT_W'(w_len_rx);
                        r_word_idx <= '0;
                        r_byte_cnt <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_word     <= {r_word[23:0], byte_in};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_word_idx <= w_idx_inc;
                end
                default: begin
                    r_word_idx <= r_word_idx;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader sitting directly upstream of the single-cycle MIPS core. It receives a program image as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, writes them sequentially into instruction memory starting at byte address 0, and holds the core stopped until the image is complete. On success it raises `cpu_run`. The core's program counter and instruction memory consume `imem_*` and `cpu_run`.

## Interface
- `MAX_WORDS`, 256: largest legal image size in words; sets instruction-memory depth.
- `CNT_W`, 16: width of the length field and of the word counter.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values.
- `load_req`  in  1  single-cycle request to start or restart a load.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  32  byte address of the write; always word-aligned (bits [1:0] = 0).
- `imem_wdata`  out  32  assembled word.
- `busy`  out  1  load in progress (LEN_HI through WRITE).
- `cpu_run`  out  1  core released; high only in DONE.
- `error`  out  1  bad length field; sticky until `load_req` or `reset`.

## Operation
- Frame: 2 length bytes (N, big-endian, MSB first), then N×4 data bytes, each word MSB first.
- Byte transfer occurs on a rising edge where `byte_valid && byte_ready`; no transfer otherwise, state held.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- IDLE: `byte_ready`=0. `load_req` -> LEN_HI.
- LEN_HI: `byte_ready`=1. Transfer -> store N[15:8], go to LEN_LO.
- LEN_LO: `byte_ready`=1. Transfer -> store N[7:0]. If N==0 or N>MAX_WORDS, go to ERROR. Otherwise clear word index and byte count, go to DATA.
- DATA: `byte_ready`=1. Each transfer shifts the byte into the word register (`word <= {word[23:0], byte_in}`) and increments the 2-bit byte count. The 4th byte goes to WRITE.
- WRITE (one cycle): `byte_ready`=0, `imem_we`=1, `imem_addr`={word_idx, 2'b00} zero-extended to 32 bits, `imem_wdata`=word. Then increment word_idx. If word_idx+1==N, go to DONE; otherwise go to DATA.
- DONE: `cpu_run`=1, `byte_ready`=0. Extra stream bytes are ignored.
- ERROR: `error`=1, `byte_ready`=0, `cpu_run`=0.
- `load_req` in any state aborts the current load and goes to LEN_HI. Word index, byte count and `error` are cleared, and `cpu_run` drops.
  - Words already written stay in memory; they are overwritten by the new image.
  - `load_req` has priority over a byte transfer in the same cycle; that byte is not consumed.
- Arithmetic: word_idx is CNT_W bits and cannot wrap, because N≤MAX_WORDS≤2^CNT_W−1. The N-vs-MAX_WORDS comparison is unsigned.

## Timing
- Reset values: `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=0, `cpu_run`=0, `error`=0, state=IDLE.
- All outputs are registered or decoded from the state register only. No combinational path from `byte_valid` to `byte_ready`.
- `imem_we` rises the cycle after the 4th byte of a word is accepted. At full stream rate each word costs 5 cycles (4 transfer + 1 WRITE).
- `cpu_run` rises the cycle after the last WRITE cycle.
- `error` rises the cycle after the LEN_LO transfer.
- `load_req` takes effect on the next edge; `busy` is high from the following cycle.
- `reset` asserted mid-load clears state immediately, without waiting for an edge. A partially written memory is not cleared.

## Test plan
- Load N=2: bytes 00 02 20 08 00 05 AC 08 00 00 with `byte_valid` held high. Required response:
  - `imem_we` pulses with addr 0x0 data 0x20080005;
  - `imem_we` pulses with addr 0x4 data 0xAC080000;
  - `cpu_run`=1 exactly one cycle after the second WRITE.
- Same image with `byte_valid` toggling every other cycle: identical writes. `byte_ready`=0 in WRITE and no byte is lost or duplicated.
- Length 00 00, then length 01 01 (257 > MAX_WORDS=256):
  - each case gives `error`=1 and `cpu_run`=0, with no `imem_we`;
  - a subsequent `load_req` clears `error`.
- `load_req` after 1.5 words of a 3-word image, then a full 1-word image 00 01 DE AD BE EF: last write is addr 0x0 data 0xDEADBEEF, then `cpu_run`=1.
- Assert `reset` asynchronously mid-word: all outputs drop to reset values before the next edge, and the state is IDLE.
- In DONE, drive 8 extra bytes: `byte_ready`=0 throughout, no `imem_we`, `cpu_run` stays 1.
